alu_result_checker: RTL and testbench

- Synthesizable self-checker that sits on the result side of the ALU, opposite the stimulus generator.
- The stimulus side pushes expected C/Flags values into an internal FIFO. Each ALU result presented on the result port pops one expected entry and is compared against it.
- Keeps pass/error counts and first-mismatch capture, so on-board runs can report pass/fail without a simulator.

---
 rtl/alu_check_pkg.sv | 22 ++
 rtl/alu_check_fifo.sv | 69 ++++++
 rtl/alu_result_checker.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_check_pkg.sv
// Shared types and default widths for the ALU result checker.
//   state_t : checker FSM states
//   entry_t : expected-value FIFO entry {c, flags, mask} at default widths
package alu_check_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_FLAG_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] c;
        logic [DEF_FLAG_W-1:0] flags;
        logic [DEF_FLAG_W-1:0] mask;
    } entry_t;

endpackage

// File: rtl/alu_check_fifo.sv
// Synchronous FIFO with show-ahead head output.
//   flush       : empties the FIFO (wins over push/pop)
//   push / pop  : ignored when full / empty respectively
//   wdata/rdata : write data / current head entry
//   full, empty, count : occupancy status
module alu_check_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
            if (pop_ok)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_result_checker.sv
// ALU result checker: queues expected C/Flags from the stimulus side and
// compares each ALU result against the oldest queued entry.
//   start/finish         : run control (start restarts, finish enters drain)
//   exp_valid/exp_ready  : expected-entry handshake (exp_c, exp_flags, exp_mask)
//   res_valid            : ALU result strobe (res_c, res_flags), no backpressure
//   busy/done/pass       : run status
//   mismatch             : pulse one cycle after a failing compare
//   underflow/missing    : sticky error causes
//   check_count/err_count/first_err_* : statistics and first-error capture
module alu_result_checker
    import alu_check_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned FLAG_W  = DEF_FLAG_W,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              finish,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_c,
    input  logic [FLAG_W-1:0] exp_flags,
    input  logic [FLAG_W-1:0] exp_mask,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_c,
    input  logic [FLAG_W-1:0] res_flags,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mismatch,
    output logic              underflow,
    output logic              missing,
    output logic [CNT_W-1:0]  check_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_c,
    output logic [DATA_W-1:0] first_err_exp
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned EW   = DATA_W + 2 * FLAG_W;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  chk_q, chk_d, err_q, err_d, fidx_q, fidx_d;
    logic [DATA_W-1:0] fc_q, fc_d, fexp_q, fexp_d;
    logic              under_q, under_d, miss_q, miss_d, mism_q, mism_d;
    logic              seen_q, seen_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [AW:0]       fifo_count, leftover;
    logic [EW-1:0]     head;
    logic [DATA_W-1:0] head_c;
    logic [FLAG_W-1:0] head_flags, head_mask;
    logic              take, cmp_fail;
    logic [AW+1:0]     err_add;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [AW+1:0]    b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign exp_ready = (state_q == ST_RUN) && !fifo_full;
    assign fifo_push = exp_valid && exp_ready;

    alu_check_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   ({exp_c, exp_flags, exp_mask}),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_c     = head[EW-1 -: DATA_W];
    assign head_flags = head[2*FLAG_W-1 -: FLAG_W];
    assign head_mask  = head[FLAG_W-1:0];
    assign take       = res_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign cmp_fail   = (res_c != head_c) || (((res_flags ^ head_flags) & head_mask) != '0);

    // Next-state, compare, counter and first-error capture logic.
    always_comb begin
        state_d    = state_q;
        chk_d      = chk_q;
        err_d      = err_q;
        under_d    = under_q;
        miss_d     = miss_q;
        mism_d     = 1'b0;
        seen_d     = seen_q;
        fidx_d     = fidx_q;
        fc_d       = fc_q;
        fexp_d     = fexp_q;
        to_d       = to_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        err_add    = '0;
        leftover   = '0;
        if (start) begin
            state_d    = ST_RUN;
            chk_d      = '0;
            err_d      = '0;
            under_d    = 1'b0;
            miss_d     = 1'b0;
            seen_d     = 1'b0;
            fidx_d     = '0;
            fc_d       = '0;
            fexp_d     = '0;
            to_d       = '0;
            fifo_flush = 1'b1;
        end else begin
            if (take) begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    chk_d    = sat_add(chk_q, (AW+2)'(1));
                    if (cmp_fail) begin
                        err_add = (AW+2)'(1);
                        mism_d  = 1'b1;
                        if (!seen_q) begin
                            seen_d = 1'b1;
                            fidx_d = chk_q;
                            fc_d   = res_c;
                            fexp_d = head_c;
                        end
                    end
                end else begin
                    // No bypass of a same-cycle push: an empty FIFO is always underflow.
                    under_d = 1'b1;
                    err_add = (AW+2)'(1);
                    if (!seen_q) begin
                        seen_d = 1'b1;
                        fidx_d = chk_q;
                        fc_d   = res_c;
                        fexp_d = '0;
                    end
                end
            end
            case (state_q)
                ST_RUN: begin
                    if (finish) begin
                        state_d = ST_DRAIN;
                        to_d    = '0;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_d = ST_DONE;
                    end else if (to_q == TO_W'(TIMEOUT)) begin
                        // Every entry still queued after this cycle's pop is an error.
                        miss_d     = 1'b1;
                        leftover   = fifo_count - (AW+1)'(fifo_pop);
                        err_add    = err_add + (AW+2)'(leftover);
                        fifo_flush = 1'b1;
                        state_d    = ST_DONE;
                        if (!seen_d && (leftover != '0)) begin
                            seen_d = 1'b1;
                            fidx_d = chk_d;
                            fc_d   = '0;
                            fexp_d = '0;
                        end
                    end else if (fifo_pop) begin
                        to_d = '0;
                    end else begin
                        to_d = TO_W'(to_q + 1'b1);
                    end
                end
                default: ;
            endcase
            err_d = sat_add(err_q, err_add);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            chk_q   <= '0;
            err_q   <= '0;
            under_q <= 1'b0;
            miss_q  <= 1'b0;
            mism_q  <= 1'b0;
            seen_q  <= 1'b0;
            fidx_q  <= '0;
            fc_q    <= '0;
            fexp_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            under_q <= under_d;
            miss_q  <= miss_d;
            mism_q  <= mism_d;
            seen_q  <= seen_d;
            fidx_q  <= fidx_d;
            fc_q    <= fc_d;
            fexp_q  <= fexp_d;
            to_q    <= to_d;
        end
    end

    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_q == '0) && !under_q && !miss_q;
    assign mismatch      = mism_q;
    assign underflow     = under_q;
    assign missing       = miss_q;
    assign check_count   = chk_q;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_c   = fc_q;
    assign first_err_exp = fexp_q;

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;
    import alu_check_pkg::*;

    localparam int DW = 16, FW = 5, DEPTH = 8, CW = 16, TMO = 64;

    logic clk = 1'b0;
    logic reset_n, start, finish, exp_valid, res_valid;
    logic [DW-1:0] exp_c, res_c;
    logic [FW-1:0] exp_flags, exp_mask, res_flags;
    logic exp_ready, busy, done, pass, mismatch, underflow, missing;
    logic [CW-1:0] check_count, err_count, first_err_idx;
    logic [DW-1:0] first_err_c, first_err_exp;

    always #5 clk = ~clk;

    alu_result_checker #(.DATA_W(DW), .FLAG_W(FW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_c(exp_c),
        .exp_flags(exp_flags), .exp_mask(exp_mask), .res_valid(res_valid),
        .res_c(res_c), .res_flags(res_flags), .busy(busy), .done(done),
        .pass(pass), .mismatch(mismatch), .underflow(underflow), .missing(missing),
        .check_count(check_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_c(first_err_c),
        .first_err_exp(first_err_exp)
    );

    int checks = 0, errors = 0;
    string cur_tag = "init";

    // Reference model: a queue of expected entries plus the run statistics.
    state_t m_st;
    entry_t q[$];
    int  m_chk, m_err, m_fidx, m_fc, m_fexp, m_to;
    bit  m_under, m_miss, m_mism, m_seen;

    function automatic int sat(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = ST_IDLE; q.delete();
        m_chk = 0; m_err = 0; m_fidx = 0; m_fc = 0; m_fexp = 0; m_to = 0;
        m_under = 0; m_miss = 0; m_mism = 0; m_seen = 0;
    endtask

    task automatic note_err(input int c, input int ex);
        if (!m_seen) begin
            m_seen = 1; m_fidx = m_chk; m_fc = c; m_fexp = ex;
        end
    endtask

    // Applies the checker rules to the inputs seen at this clock edge.
    task automatic model_step();
        int pre; bit rdy, popped, bad; entry_t e;
        if (!reset_n) begin model_reset(); return; end
        if (start) begin
            model_reset(); m_st = ST_RUN; return;
        end
        pre = q.size(); rdy = (m_st == ST_RUN) && (pre < DEPTH);
        m_mism = 0; popped = 0;
        if (res_valid && (m_st == ST_RUN || m_st == ST_DRAIN)) begin
            if (pre > 0) begin
                e = q.pop_front(); popped = 1;
                bad = (res_c != e.c) || (((res_flags ^ e.flags) & e.mask) != 0);
                if (bad) begin
                    note_err(int'(res_c), int'(e.c));
                    m_err = sat(m_err, 1); m_mism = 1;
                end
                m_chk = sat(m_chk, 1);
            end else begin
                note_err(int'(res_c), 0);
                m_under = 1; m_err = sat(m_err, 1);
            end
        end
        if (exp_valid && rdy) q.push_back('{c: exp_c, flags: exp_flags, mask: exp_mask});
        case (m_st)
            ST_RUN: if (finish) begin m_st = ST_DRAIN; m_to = 0; end
            ST_DRAIN: begin
                if (pre == 0) m_st = ST_DONE;
                else if (m_to == TMO) begin
                    m_miss = 1;
                    if (q.size() > 0) note_err(0, 0);
                    m_err = sat(m_err, q.size());
                    q.delete(); m_st = ST_DONE;
                end else m_to = popped ? 0 : m_to + 1;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string t);
        chk({t, ".exp_ready"}, exp_ready, (m_st == ST_RUN) && (q.size() < DEPTH));
        chk({t, ".busy"}, busy, (m_st == ST_RUN) || (m_st == ST_DRAIN));
        chk({t, ".done"}, done, m_st == ST_DONE);
        chk({t, ".pass"}, pass, (m_st == ST_DONE) && m_err == 0 && !m_under && !m_miss);
        chk({t, ".mismatch"}, mismatch, m_mism);
        chk({t, ".underflow"}, underflow, m_under);
        chk({t, ".missing"}, missing, m_miss);
        chk({t, ".check_count"}, check_count, m_chk);
        chk({t, ".err_count"}, err_count, m_err);
        chk({t, ".first_err_idx"}, first_err_idx, m_fidx);
        chk({t, ".first_err_c"}, first_err_c, m_fc);
        chk({t, ".first_err_exp"}, first_err_exp, m_fexp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all(cur_tag);
    endtask

    task automatic idle_in();
        start = 0; finish = 0; exp_valid = 0; res_valid = 0;
        exp_c = '0; exp_flags = '0; exp_mask = '0; res_c = '0; res_flags = '0;
    endtask

    task automatic do_start();
        idle_in(); start = 1; tick(); start = 0;
    endtask

    task automatic push(input int c, input int f, input int m);
        exp_valid = 1; exp_c = DW'(c); exp_flags = FW'(f); exp_mask = FW'(m);
    endtask

    task automatic result(input int c, input int f);
        res_valid = 1; res_c = DW'(c); res_flags = FW'(f);
    endtask

    task automatic finish_and_wait(input int max_cycles);
        idle_in(); finish = 1; tick(); finish = 0;
        for (int i = 0; i < max_cycles && m_st != ST_DONE; i++) tick();
        chk({cur_tag, ".reached_done"}, done, 1'b1);
    endtask

    initial begin
        entry_t h;
        idle_in();
        reset_n = 0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1;

        // Clean run of 32 matching results, each one cycle behind its push.
        cur_tag = "clean";
        do_start();
        for (int i = 0; i <= 32; i++) begin
            idle_in();
            if (i < 32) push(i + 3 * i, 0, 0);
            if (i > 0) result(4 * (i - 1), $urandom_range(31));
            tick();
        end
        finish_and_wait(20);
        chk("clean.pass", pass, 1'b1);
        chk("clean.check_count", check_count, 32);
        chk("clean.err_count", err_count, 0);

        // Single data mismatch.
        cur_tag = "mism";
        do_start();
        push(10, 0, 0); tick(); idle_in();
        result(11, 0); tick(); idle_in();
        chk("mism.pulse", mismatch, 1'b1);
        tick();
        chk("mism.pulse_end", mismatch, 1'b0);
        finish_and_wait(20);
        chk("mism.err_count", err_count, 1);
        chk("mism.first_idx", first_err_idx, 0);
        chk("mism.first_c", first_err_c, 11);
        chk("mism.first_exp", first_err_exp, 10);
        chk("mism.pass", pass, 1'b0);

        // Flag mask selects which flag bits are compared.
        cur_tag = "mask";
        do_start();
        push(1, 5'b00001, 5'b00001); tick();
        push(1, 5'b00001, 5'b00010); tick(); idle_in();
        result(1, 5'b00011); tick(); idle_in();
        chk("mask.masked_ok", err_count, 0);
        result(1, 5'b00011); tick(); idle_in();
        chk("mask.unmasked_err", err_count, 1);

        // Full FIFO, push+pop at 7 entries, then underflow.
        cur_tag = "full";
        do_start();
        for (int i = 0; i < 8; i++) begin push(i, 0, 0); tick(); end
        chk("full.ready_low", exp_ready, 1'b0);
        push(99, 0, 0); tick(); idle_in();
        result(0, 0); tick(); idle_in();
        push(8, 0, 0); result(1, 0); tick(); idle_in();
        chk("full.occ7_ready", exp_ready, 1'b1);
        push(9, 0, 0); tick(); idle_in();
        chk("full.occ8_ready", exp_ready, 1'b0);
        for (int i = 2; i <= 9; i++) begin result(i, 0); tick(); end
        idle_in();
        chk("full.no_err", err_count, 0);
        result(55, 0); tick(); idle_in();
        chk("full.underflow", underflow, 1'b1);
        chk("full.uf_err", err_count, 1);
        chk("full.uf_first_exp", first_err_exp, 0);

        // Randomized traffic, mostly matching results with occasional corruption.
        cur_tag = "rand";
        do_start();
        for (int i = 0; i < 400; i++) begin
            idle_in();
            if ($urandom_range(1) == 1)
                push($urandom_range(65535), $urandom_range(31), $urandom_range(31));
            if ($urandom_range(2) == 0) begin
                if (q.size() > 0) begin
                    h = q[0];
                    result(($urandom_range(7) == 0) ? int'(h.c ^ 16'h1) : int'(h.c),
                           int'(h.flags ^ FW'($urandom_range(31))));
                end else if ($urandom_range(7) == 0) begin
                    result($urandom_range(65535), 0);
                end
            end
            tick();
        end
        finish_and_wait(100);

        // Drain timeout with two entries left.
        cur_tag = "timeout";
        do_start();
        push(1, 0, 0); tick(); push(2, 0, 0); tick(); push(3, 0, 0); tick(); idle_in();
        result(1, 0); tick(); idle_in();
        finish_and_wait(80);
        chk("timeout.missing", missing, 1'b1);
        chk("timeout.err_count", err_count, 2);
        chk("timeout.pass", pass, 1'b0);

        // Asynchronous reset in the middle of DRAIN.
        cur_tag = "areset";
        do_start();
        push(5, 0, 0); tick(); push(6, 0, 0); tick(); idle_in();
        result(7, 0); tick(); idle_in();
        finish = 1; tick(); finish = 0;
        tick(); tick();
        #2 reset_n = 0;
        #1;
        chk("areset.busy", busy, 1'b0);
        chk("areset.err_count", err_count, 0);
        chk("areset.check_count", check_count, 0);
        chk("areset.first_err_c", first_err_c, 0);
        chk("areset.first_err_exp", first_err_exp, 0);
        chk("areset.exp_ready", exp_ready, 1'b0);
        chk("areset.mismatch", mismatch, 1'b0);
        model_reset();
        tick();
        reset_n = 1;
        do_start();
        chk("areset.restart_busy", busy, 1'b1);
        chk("areset.restart_ready", exp_ready, 1'b1);
        push(42, 0, 0); tick(); idle_in();
        result(42, 0); tick(); idle_in();
        finish_and_wait(20);
        chk("areset.restart_pass", pass, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
